// File: rtl/cic_pool_flatten_sched.sv
// cic_pool_flatten_sched: Layer-1/Layer-2 scheduler for the CNN image core.
// Walks the two Layer-0 maps (L0K0, L0K1) in 2x2 windows and reduces each
// window by signed maximum. The result goes to L1K0/L1K1 at the pixel index.
// The interleaved flatten copy goes to L2F at index 2*pixel+kernel.
//
// Build option: define CIC_FLATTEN_EN to include the L2F write (W2 state,
// 7 cycles per window). Without it, W1 advances directly (6 cycles per window)
// and L2F is never selected.
//
// Memory handshake: reads are fire-and-forget. When crd is high in a cycle,
// cdata_rd carries the addressed word in the following cycle; there is no
// stall. When cwr is high, the write of cdata_wr to caddr_wr in memory csel
// commits at the end of that cycle. crd and cwr are never high together, and
// csel is 000 whenever neither is high.
module cic_pool_flatten_sched #(
  parameter int IMG_W = 64,
  parameter int DW    = 20,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    csel,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr
);

  localparam int HALF = IMG_W / 2;
  localparam int CW   = $clog2(HALF);
  localparam int IW   = 2 * CW;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_L0K0 = 3'b001;
  localparam logic [2:0] SEL_L0K1 = 3'b010;
  localparam logic [2:0] SEL_L1K0 = 3'b011;
  localparam logic [2:0] SEL_L1K1 = 3'b100;
`ifdef CIC_FLATTEN_EN
  localparam logic [2:0] SEL_L2F  = 3'b101;
`endif

  typedef enum logic [3:0] {
    IDLE, R0, R1, R2, R3, R4, W1, W2, DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] pix;     // output pixel index, raster order
  logic          kern;    // kernel currently being pooled
  logic [DW-1:0] max_q;   // running window maximum

  // Top-left read address of the window for output pixel p:
  // 2*row*IMG_W + 2*col, which is just the row and column bits spread out.
  function automatic logic [AW-1:0] base_of(input logic [IW-1:0] p);
    return AW'({p[IW-1:CW], 1'b0, p[CW-1:0], 1'b0});
  endfunction

  logic [AW-1:0] base;
  logic [IW-1:0] nxt_pix;
  logic          nxt_kern;
  logic          last_win;
  logic [DW-1:0] max_next;

  // Window addressing, loop advance and signed max compare (ties keep old).
  always_comb begin
    base     = base_of(pix);
    nxt_kern = ~kern;
    nxt_pix  = kern ? pix + IW'(1) : pix;
    last_win = (&pix) & kern;
    max_next = ($signed(cdata_rd) > $signed(max_q)) ? cdata_rd : max_q;
  end

  // Scheduler FSM; every output is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pix      <= '0;
      kern     <= 1'b0;
      max_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      csel     <= SEL_NONE;
      crd      <= 1'b0;
      caddr_rd <= '0;
      cwr      <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          pix  <= '0;
          kern <= 1'b0;
          if (start) begin
            state    <= R0;
            busy     <= 1'b1;
            crd      <= 1'b1;
            csel     <= SEL_L0K0;
            caddr_rd <= base_of('0);
          end
        end
        R0: begin
          state    <= R1;
          caddr_rd <= base + AW'(1);
        end
        R1: begin
          state    <= R2;
          max_q    <= cdata_rd;
          caddr_rd <= base + AW'(IMG_W);
        end
        R2: begin
          state    <= R3;
          max_q    <= max_next;
          caddr_rd <= base + AW'(IMG_W + 1);
        end
        R3: begin
          state <= R4;
          max_q <= max_next;
          crd   <= 1'b0;
          csel  <= SEL_NONE;
        end
        R4: begin
          state    <= W1;
          max_q    <= max_next;
          cdata_wr <= max_next;
          cwr      <= 1'b1;
          csel     <= kern ? SEL_L1K1 : SEL_L1K0;
          caddr_wr <= AW'(pix);
        end
`ifdef CIC_FLATTEN_EN
        W1: begin
          state    <= W2;
          csel     <= SEL_L2F;
          caddr_wr <= AW'({pix, kern});
        end
        W2: begin
`else
        W1: begin
`endif
          cwr <= 1'b0;
          if (last_win) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            csel  <= SEL_NONE;
          end else begin
            state    <= R0;
            pix      <= nxt_pix;
            kern     <= nxt_kern;
            crd      <= 1'b1;
            csel     <= nxt_kern ? SEL_L0K1 : SEL_L0K0;
            caddr_rd <= base_of(nxt_pix);
          end
        end
        DONE: begin
          state <= IDLE;
          pix   <= '0;
          kern  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          crd   <= 1'b0;
          cwr   <= 1'b0;
          csel  <= SEL_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cic_pool_flatten_sched.sv
// Bench for cic_pool_flatten_sched: synchronous memory model for Layer 0,
// golden model feeding read/write scoreboards, directed corner windows,
// a repeated start that must be ignored, and a reset in mid-run.
module tb_cic_pool_flatten_sched;

  localparam int IMG_W = 64;
  localparam int DW    = 20;
  localparam int AW    = 12;
  localparam int HALF  = IMG_W / 2;
  localparam int NPIX  = HALF * HALF;
`ifdef CIC_FLATTEN_EN
  localparam int WIN_CYC = 7;
`else
  localparam int WIN_CYC = 6;
`endif
  localparam int RUN_CYC = 2 * NPIX * WIN_CYC;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [2:0]    csel;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;

  logic [DW-1:0] l0k0 [IMG_W*IMG_W];
  logic [DW-1:0] l0k1 [IMG_W*IMG_W];
  logic [DW-1:0] l1k0_cap [NPIX];
  logic [DW-1:0] l1k1_cap [NPIX];
  logic [DW-1:0] l2f_cap [2*NPIX];

  logic [34:0] rd_exp_q[$];
  logic [34:0] wr_exp_q[$];

  int total;
  int bad;
  int overlap_cnt;
  int idle_sel_cnt;

  cic_pool_flatten_sched #(.IMG_W(IMG_W), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .csel(csel), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layer-0 memories: synchronous read, data valid the cycle after crd.
  initial cdata_rd = '0;
  always @(posedge clk) begin
    if (crd) begin
      if (csel == 3'b001) cdata_rd <= l0k0[caddr_rd];
      else if (csel == 3'b010) cdata_rd <= l0k1[caddr_rd];
      else cdata_rd <= '0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Golden model: expected read and write streams for a full run.
  task automatic build_golden();
    logic [2:0]    s;
    logic [AW-1:0] a;
    logic [DW-1:0] v [4];
    logic [DW-1:0] m;
    int base;
    rd_exp_q.delete();
    wr_exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      for (int k = 0; k < 2; k++) begin
        base = 2 * (i / HALF) * IMG_W + 2 * (i % HALF);
        s = (k == 0) ? 3'b001 : 3'b010;
        for (int j = 0; j < 4; j++) begin
          a = AW'(base + (j / 2) * IMG_W + (j % 2));
          v[j] = (k == 0) ? l0k0[a] : l0k1[a];
          rd_exp_q.push_back({20'd0, s, a});
        end
        m = v[0];
        for (int j = 1; j < 4; j++)
          if ($signed(v[j]) > $signed(m)) m = v[j];
        s = (k == 0) ? 3'b011 : 3'b100;
        a = AW'(i);
        wr_exp_q.push_back({s, a, m});
`ifdef CIC_FLATTEN_EN
        s = 3'b101;
        a = AW'(2 * i + k);
        wr_exp_q.push_back({s, a, m});
`endif
      end
    end
  endtask

  // Scoreboard monitor: pops expected reads/writes as the DUT issues them.
  always @(negedge clk) begin
    logic [34:0] e;
    if (!reset) begin
      if (crd && cwr) overlap_cnt++;
      if (!crd && !cwr && csel != 3'b000) idle_sel_cnt++;
      if (crd) begin
        if (rd_exp_q.size() == 0) check("rd_extra", {csel, caddr_rd}, 0);
        else begin
          e = rd_exp_q.pop_front();
          check("rd_seq", {20'd0, csel, caddr_rd}, e);
        end
      end
      if (cwr) begin
        if (csel == 3'b011) l1k0_cap[caddr_wr[9:0]] = cdata_wr;
        if (csel == 3'b100) l1k1_cap[caddr_wr[9:0]] = cdata_wr;
        if (csel == 3'b101) l2f_cap[caddr_wr[10:0]] = cdata_wr;
        if (wr_exp_q.size() == 0) check("wr_extra", {csel, caddr_wr, cdata_wr}, 0);
        else begin
          e = wr_exp_q.pop_front();
          check("wr_seq", {csel, caddr_wr, cdata_wr}, e);
        end
      end
    end
  end

  task automatic clear_caps();
    for (int i = 0; i < NPIX; i++) begin
      l1k0_cap[i] = '0;
      l1k1_cap[i] = '0;
    end
    for (int i = 0; i < 2 * NPIX; i++) l2f_cap[i] = '0;
  endtask

  // Full run from a start pulse (caller is at a negedge, DUT idle).
  task automatic run_full(input bit restart_mid);
    int cnt;
    bit got_done;
    overlap_cnt  = 0;
    idle_sel_cnt = 0;
    clear_caps();
    build_golden();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    got_done = 1'b0;
    while (!got_done && cnt <= RUN_CYC + 50) begin
      if (cnt == 0) begin
        check("start_crd", crd, 1);
        check("start_csel", csel, 3'b001);
        check("start_addr", caddr_rd, 0);
        check("start_busy", busy, 1);
      end
      if (done) got_done = 1'b1;
      else begin
        start = restart_mid && (cnt == 100);
        @(negedge clk);
        cnt++;
      end
    end
    start = 1'b0;
    check("done_seen", got_done, 1);
    check("done_cycle", cnt, RUN_CYC);
    check("done_busy", busy, 0);
    check("rd_left", rd_exp_q.size(), 0);
    check("wr_left", wr_exp_q.size(), 0);
    check("overlap", overlap_cnt, 0);
    check("idle_csel", idle_sel_cnt, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  task automatic corner_checks();
    check("l1k0_0", l1k0_cap[0], 20'd9);
    check("l1k1_1023", l1k1_cap[1023], 20'hFFFFF);
`ifdef CIC_FLATTEN_EN
    check("l2f_0", l2f_cap[0], 20'd9);
    check("l2f_2047", l2f_cap[2047], 20'hFFFFF);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_crd"}, crd, 0);
    check({tag, "_cwr"}, cwr, 0);
    check({tag, "_csel"}, csel, 0);
    check({tag, "_rdaddr"}, caddr_rd, 0);
    check({tag, "_wraddr"}, caddr_wr, 0);
    check({tag, "_wrdata"}, cdata_wr, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    for (int a = 0; a < IMG_W * IMG_W; a++) begin
      l0k0[a] = DW'($urandom_range(0, (1 << DW) - 1));
      l0k1[a] = DW'($urandom_range(0, (1 << DW) - 1));
    end
    l0k0[0]    = DW'(5);
    l0k0[1]    = DW'(-3);
    l0k0[64]   = DW'(9);
    l0k0[65]   = DW'(9);
    l0k1[4030] = DW'(-7);
    l0k1[4031] = DW'(-1);
    l0k1[4094] = DW'(-4);
    l0k1[4095] = DW'(-2);

    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // run 1 with an ignored second start at cycle 100
    run_full(1'b1);
    corner_checks();

    // run 2 aborted by reset at cycle 500
    build_golden();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("midrst");
    rd_exp_q.delete();
    wr_exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // run 3 must reproduce the full results
    run_full(1'b0);
    corner_checks();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cic_pool_flatten_sched.md
# cic_pool_flatten_sched

Layer-1/Layer-2 scheduler for the CNN image core. Once the convolution engine has filled the Layer-0 result memories (L0K0, L0K1), this block takes sole ownership of the shared result-memory port (`csel`, `crd`, `cwr`, addresses). It walks the 64×64 Layer-0 maps in 2×2 windows, reduces each window by signed maximum, writes the result to L1K0/L1K1, and writes the interleaved flatten result to L2F. It sits between the convolution stage and the top-level memory interface and signals completion to the top controller.

## Interface
- `IMG_W`, default 64: Layer-0 map width/height (power of two).
- `DW`, default 20: data width, signed fixed point.
- `AW`, default 12: memory address width.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: one-cycle pulse from the conv engine when Layer 0 is complete.
- `busy`  out  1: high while scheduling.
- `done`  out  1: one-cycle pulse after the last write.
- `csel`  out  3: memory select: 000 none, 001 L0K0, 010 L0K1, 011 L1K0, 100 L1K1, 101 L2F.
- `crd`  out  1: read enable.
- `caddr_rd`  out  AW: read address.
- `cdata_rd`  in  DW: read data, valid the cycle after `crd`.
- `cwr`  out  1: write enable.
- `caddr_wr`  out  AW: write address.
- `cdata_wr`  out  DW: write data.

## Operation
- FSM states: IDLE, R0, R1, R2, R3, R4, W1, W2, DONE.
- IDLE: `start`=1 at a clock edge → R0. Otherwise stay in IDLE.
- Loop order:
  - outer: output pixel i = r·(IMG_W/2)+c, raster order, i = 0..1023;
  - inner: kernel k = 0 then 1.
- R0–R3, read phase:
  - `crd`=1, `csel`=001 (k=0) or 010 (k=1).
  - `caddr_rd` = base, base+1, base+IMG_W, base+IMG_W+1, where base = 2r·IMG_W + 2c.
- Capture:
  - R1–R4 each capture `cdata_rd` (R4 has `crd`=0).
  - The first capture loads the max register; later captures replace it only if the new value is strictly greater (signed DW-bit compare). Ties keep the earlier value.
- W1:
  - `cwr`=1, `csel`=011 (k=0) or 100 (k=1).
  - `caddr_wr`=i, `cdata_wr`=max.
- W2:
  - `cwr`=1, `csel`=101, `caddr_wr`=2i+k, `cdata_wr`=max.
  - Then advance: k=0 → k=1, go to R0. k=1 → i+1, k=0, go to R0. Last window (i=1023, k=1) → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `start` while not in IDLE is ignored.
- No wrap past i=1023. Counters clear on entering IDLE.

## Timing
- All outputs are registered. Reset values:
  - `busy`, `done`, `crd`, `cwr` = 0;
  - `csel` = 000;
  - `caddr_rd`, `caddr_wr`, `cdata_wr` = 0.
- Start latency: the edge sampling `start` is followed immediately by R0 (`crd`=1) and `busy`=1 in the same cycle.
- `crd` and `cwr` are never both high. `csel`=000 whenever both are low.
- Per window: 7 cycles (R0–R4, W1, W2). Full run: 2048 × 7 = 14336 busy cycles, then the `done` cycle, during which `busy`=0.
- Reset asserted mid-operation: all outputs return to reset values asynchronously, the FSM returns to IDLE, and no partial write completes. A new `start` after reset release begins again from i=0.

## Configuration
- `CIC_FLATTEN_EN` defined: behaviour as above. W2 present, 7 cycles/window, 14336 busy cycles.
- `CIC_FLATTEN_EN` undefined:
  - W2 removed; W1 advances directly. 6 cycles/window, 12288 busy cycles.
  - `csel`=101 is never driven. L2F is left to the downstream block.

## Test plan
- Reset asserted → all outputs zero, `csel`=000. `start` pulse → `crd`=1, `caddr_rd`=0, `csel`=001 on the next cycle.
- L0K0 addresses 0, 1, 64, 65 = 5, 0xFFFFD (−3), 9, 9 → L1K0[0]=9. Write order is 9 then 9 (tie keeps earlier). With the macro, L2F[0]=9.
- L0K1 window at i=1023 all negative (−7, −1, −4, −2) → L1K1[1023]=0xFFFFF and L2F[2047]=0xFFFFF.
- Full run with random Layer-0 data against a golden model:
  - every L1/L2F entry matches;
  - `done` pulses exactly 14336 cycles after the first R0 (12288 without the macro);
  - `crd`/`cwr` never overlap.
- `start` pulsed again at cycle 100 of a run → ignored. Address sequence and completion time unchanged.
- `reset` asserted at cycle 500 → outputs zero immediately, no write in that cycle. A later `start` reproduces the full-run results.
